// File: rtl/dct_mac_pkg.sv
// Shared definitions for the DCT multiply-accumulate datapath.
//   MODE_MUL / MODE_DOT : encodings of the 'mode' input
//   calc_acc_w()        : accumulator width that can hold acc_len full
//                         products without overflow
package dct_mac_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DOT = 1'b1;

    // Product width plus enough headroom bits for acc_len terms.
    function automatic int calc_acc_w(input int din0_w, input int din1_w, input int acc_len);
        return din0_w + din1_w - 1 + $clog2(acc_len);
    endfunction

endpackage

// File: rtl/dct_mac_mul_pipe.sv
// Signed multiplier followed by a NUM_STAGE-deep register pipeline.
// The product is formed from the raw operands and registered in stage 0;
// later stages shift it along, which maps onto DSP48 M/P registers.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (valid bits only)
//   en           : pipeline enable; all stages hold when low
//   in_valid     : operand valid, carried alongside the product
//   a, b         : signed operands
//   tag_in       : sideband bits that travel with the product
//   prod         : signed product truncated to A_W+B_W-1 bits, last stage
//   out_valid    : valid bit of the last stage
//   tag_out      : sideband bits of the last stage
module dct_mac_mul_pipe #(
    parameter int A_W       = 16,
    parameter int B_W       = 15,
    parameter int NUM_STAGE = 3,
    parameter int TAG_W     = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic signed [A_W-1:0]       a,
    input  logic signed [B_W-1:0]       b,
    input  logic        [TAG_W-1:0]     tag_in,
    output logic signed [A_W+B_W-2:0]   prod,
    output logic                        out_valid,
    output logic        [TAG_W-1:0]     tag_out
);

    localparam int P_W = A_W + B_W - 1;
    localparam int F_W = A_W + B_W;

    logic signed [F_W-1:0] a_ext_s;
    logic signed [F_W-1:0] b_ext_s;
    logic signed [F_W-1:0] full_s;
    logic signed [P_W-1:0] prod_s;

    logic signed [P_W-1:0]   prod_r [NUM_STAGE];
    logic        [TAG_W-1:0] tag_r  [NUM_STAGE];
    logic        [NUM_STAGE-1:0] vld_r;

    assign a_ext_s = F_W'(a);
    assign b_ext_s = F_W'(b);
    assign full_s  = a_ext_s * b_ext_s;
    // The top bit is only needed for (-2^(A_W-1))*(-2^(B_W-1)); it is dropped.
    assign prod_s  = full_s[P_W-1:0];

    // Data and tag shift register; left without reset so it packs into the DSP.
    always_ff @(posedge clk) begin
        if (en) begin
            prod_r[0] <= prod_s;
            tag_r[0]  <= tag_in;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_r[i] <= prod_r[i-1];
                tag_r[i]  <= tag_r[i-1];
            end
        end
    end

    // Valid shift register, cleared on reset so stale data is never used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
        end else if (en) begin
            vld_r[0] <= in_valid;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_r[i] <= vld_r[i-1];
            end
        end
    end

    assign prod      = prod_r[NUM_STAGE-1];
    assign tag_out   = tag_r[NUM_STAGE-1];
    assign out_valid = vld_r[NUM_STAGE-1];

endmodule

// File: rtl/dct_mac_pipe_16s.sv
// Pipelined signed MAC for DCT butterflies.
// mode=0 : every accepted beat yields round/saturate(din0*din1).
// mode=1 : ACC_LEN consecutive beats are summed, one result per vector.
// Results appear NUM_STAGE+1 enabled cycles after the (last) beat accept.
// Ports:
//   ap_clk, ap_rst_n     : clock, asynchronous active-low reset
//   mode                 : 0 per-beat product, 1 dot product (sampled at beat 0)
//   in_valid / in_ready  : operand handshake (in_ready is the global enable)
//   din0, din1           : signed operands
//   out_valid / out_ready: result handshake
//   dout                 : (sum + 2^(SHIFT-1)) >>> SHIFT, saturated
module dct_mac_pipe_16s
    import dct_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 15,
    parameter int NUM_STAGE  = 3,
    parameter int ACC_LEN    = 8,
    parameter int SHIFT      = 13,
    parameter int DOUT_WIDTH = 16
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout
);

    localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH - 1;
    localparam int ACC_W  = calc_acc_w(DIN0_WIDTH, DIN1_WIDTH, ACC_LEN);
    localparam int CNT_W  = $clog2(ACC_LEN);
    localparam int RND_W  = ACC_W + 1;

    localparam logic signed [RND_W-1:0] RND_HALF = {{(RND_W-1){1'b0}}, 1'b1} << (SHIFT-1);
    localparam logic signed [RND_W-1:0] SAT_MAX  = {{(RND_W-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [RND_W-1:0] SAT_MIN  = {{(RND_W-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    logic                    ce_s;
    logic                    accept_s;
    logic                    first_s;
    logic                    eff_mode_s;
    logic                    last_s;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic                    mode_r;

    logic signed [PROD_W-1:0] p_prod_s;
    logic                     p_vld_s;
    logic [2:0]               p_tag_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [RND_W-1:0]  rnd_s;
    logic signed [RND_W-1:0]  shf_s;
    logic signed [DOUT_WIDTH-1:0] sat_s;

    logic signed [ACC_W-1:0]      acc_r;
    logic                         out_valid_r;
    logic signed [DOUT_WIDTH-1:0] dout_r;

    // A held result freezes the whole pipeline, so nothing can be lost.
    assign ce_s     = !out_valid_r || out_ready;
    assign in_ready = ce_s;
    assign accept_s = in_valid && ce_s;

    // Beat classification: mode is taken from the port only on beat 0.
    always_comb begin
        first_s    = (cnt_r == '0);
        eff_mode_s = mode_r;
        if (first_s) begin
            eff_mode_s = mode;
        end else begin
            eff_mode_s = mode_r;
        end
        last_s    = (eff_mode_s == MODE_MUL) || (cnt_r == CNT_W'(ACC_LEN-1));
        cnt_nxt_s = '0;
        if ((eff_mode_s == MODE_DOT) && !last_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_nxt_s = '0;
        end
    end

    // Beat counter and captured vector mode.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_r  <= '0;
            mode_r <= MODE_MUL;
        end else if (accept_s) begin
            cnt_r <= cnt_nxt_s;
            if (first_s) begin
                mode_r <= mode;
            end
        end
    end

    // Tag layout: [2] captured mode, [1] first beat, [0] last beat.
    dct_mac_mul_pipe #(
        .A_W       (DIN0_WIDTH),
        .B_W       (DIN1_WIDTH),
        .NUM_STAGE (NUM_STAGE),
        .TAG_W     (3)
    ) u_mul (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .en        (ce_s),
        .in_valid  (accept_s),
        .a         (din0),
        .b         (din1),
        .tag_in    ({eff_mode_s, first_s, last_s}),
        .prod      (p_prod_s),
        .out_valid (p_vld_s),
        .tag_out   (p_tag_s)
    );

    // Accumulate, round half up, then clamp to the output range.
    always_comb begin
        prod_ext_s = {{(ACC_W-PROD_W){p_prod_s[PROD_W-1]}}, p_prod_s};
        if (p_tag_s[1] || (p_tag_s[2] == MODE_MUL)) begin
            sum_s = prod_ext_s;
        end else begin
            sum_s = acc_r + prod_ext_s;
        end
        rnd_s = {sum_s[ACC_W-1], sum_s} + RND_HALF;
        shf_s = rnd_s >>> SHIFT;
        if (shf_s > SAT_MAX) begin
            sat_s = SAT_MAX[DOUT_WIDTH-1:0];
        end else if (shf_s < SAT_MIN) begin
            sat_s = SAT_MIN[DOUT_WIDTH-1:0];
        end else begin
            sat_s = shf_s[DOUT_WIDTH-1:0];
        end
    end

    // Accumulator and output register; the next vector's first product
    // overwrites the accumulator directly, so vectors run back to back.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_r       <= '0;
            out_valid_r <= 1'b0;
            dout_r      <= '0;
        end else if (ce_s) begin
            if (p_vld_s) begin
                acc_r <= sum_s;
            end
            out_valid_r <= p_vld_s && p_tag_s[0];
            if (p_vld_s && p_tag_s[0]) begin
                dout_r <= sat_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign dout      = dout_r;

endmodule

// File: tb/tb_dct_mac_pipe_16s.sv
// Directed self-checking bench for dct_mac_pipe_16s (default parameters).
module tb_dct_mac_pipe_16s;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic               mode = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] din0 = 16'sd0;
    logic signed [14:0] din1 = 15'sd0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] dout;

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    logic bp_en = 1'b0;
    int drop_left = 0;
    logic signed [31:0] q[$];
    logic held_v = 1'b0;
    logic signed [15:0] held_d = 16'sd0;

    dct_mac_pipe_16s dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    always #5 ap_clk = ~ap_clk;

    // Sink: optionally drops out_ready for 1-5 cycles at random.
    always @(posedge ap_clk) begin
        #1;
        if (bp_en) begin
            if (drop_left > 0) begin
                out_ready = 1'b0;
                drop_left--;
            end else if ($urandom_range(0, 2) == 0) begin
                out_ready = 1'b0;
                drop_left = $urandom_range(1, 5) - 1;
            end else begin
                out_ready = 1'b1;
            end
        end else begin
            out_ready = 1'b1;
        end
    end

    // Collector and handshake monitor, sampled mid-cycle.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (out_valid && out_ready) q.push_back(dout);
            if (out_valid && !out_ready) begin
                checks++;
                assert (in_ready === 1'b0) else begin
                    errors++;
                    $error("FAIL in_ready_stall: observed %0b expected 0", in_ready);
                end
            end
            if (held_v) begin
                checks++;
                assert (out_valid === 1'b1 && dout === held_d) else begin
                    errors++;
                    $error("FAIL hold_stable: observed v=%0b d=%0d expected v=1 d=%0d", out_valid, dout, held_d);
                end
            end
            held_v = out_valid && !out_ready;
            held_d = dout;
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #2;
    endtask

    // Present one beat and return once it has been accepted.
    task automatic beat(input logic m, input int a, input int b);
        logic took;
        mode = m;
        din0 = 16'(a);
        din1 = 15'(b);
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            took = in_ready;
            if (!took) stalls++;
            step();
            if (took) return;
        end
        chk("beat_timeout", 32'sd0, 32'sd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Wait for n results, then confirm nothing extra shows up.
    task automatic wait_results(input string tag, input int n);
        int t;
        t = 0;
        while (q.size() < n && t < 300) begin
            step();
            t++;
        end
        repeat (12) step();
        chk(tag, q.size(), n);
    endtask

    function automatic logic signed [31:0] qat(input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    initial begin
        // Reset state
        #3;
        chk("rst_out_valid", out_valid, 32'sd0);
        chk("rst_dout", dout, 32'sd0);
        step();
        step();
        ap_rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 32'sd1);

        // Mode 0 latency: 8192*100 -> 100 four cycles after accept
        beat(1'b0, 8192, 100);
        idle();
        chk("lat_c1", out_valid, 32'sd0);
        step();
        chk("lat_c2", out_valid, 32'sd0);
        step();
        chk("lat_c3", out_valid, 32'sd0);
        step();
        chk("lat_c4_valid", out_valid, 32'sd1);
        chk("lat_c4_dout", dout, 32'sd100);
        wait_results("lat_count", 1);
        q.delete();

        // Mode 0 boundary values streamed back to back
        beat(1'b0, -32768, 16383);
        beat(1'b0, 1, 4096);
        beat(1'b0, -1, 4096);
        beat(1'b0, 8192, -100);
        beat(1'b0, 32767, 16383);
        idle();
        wait_results("m0_count", 5);
        chk("m0_sat_neg", qat(0), -32768);
        chk("m0_round_up", qat(1), 1);
        chk("m0_round_neg", qat(2), 0);
        chk("m0_neg_half", qat(3), -100);
        chk("m0_sat_pos", qat(4), 32767);
        q.delete();

        // Mode 1 single vector
        for (int i = 0; i < 8; i++) beat(1'b1, 4096, 4096);
        idle();
        wait_results("m1_count", 1);
        chk("m1_value", qat(0), 16384);
        q.delete();

        // Two consecutive vectors, no stall with out_ready high
        stalls = 0;
        for (int i = 0; i < 8; i++) beat(1'b1, 4096, 4096);
        for (int i = 0; i < 8; i++) beat(1'b1, (i + 1) * 100, 8192);
        idle();
        chk("b2b_no_stall", stalls, 0);
        wait_results("b2b_count", 2);
        chk("b2b_v0", qat(0), 16384);
        chk("b2b_v1", qat(1), 3600);
        q.delete();

        // Three vectors under random output backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) beat(1'b1, 4096, 4096);
        for (int i = 0; i < 8; i++) beat(1'b1, (i + 1) * 100, 8192);
        for (int i = 0; i < 8; i++) beat(1'b1, -1000, 8192);
        idle();
        wait_results("bp_count", 3);
        bp_en = 1'b0;
        step();
        step();
        chk("bp_v0", qat(0), 16384);
        chk("bp_v1", qat(1), 3600);
        chk("bp_v2", qat(2), -8000);
        q.delete();

        // Reset after five beats discards the partial sum
        for (int i = 0; i < 5; i++) beat(1'b1, 4096, 4096);
        idle();
        ap_rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 32'sd0);
        chk("arst_dout", dout, 32'sd0);
        step();
        ap_rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) beat(1'b1, 1, 8192);
        idle();
        wait_results("arst_count", 1);
        chk("arst_value", qat(0), 8);
        q.delete();

        // Mode dropped at beat 3: vector still completes as a dot product
        for (int i = 0; i < 8; i++) beat((i == 3) ? 1'b0 : 1'b1, 4096, 4096);
        beat(1'b0, 1, 4096);
        idle();
        wait_results("mchg_count", 2);
        chk("mchg_dot", qat(0), 16384);
        chk("mchg_mul", qat(1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dct_mac_pipe_16s.md
DCT_MAC_PIPE_16S -- requirements
Module: dct_mac_pipe_16s

Interface
REQ-001 SHALL provide parameter DIN0_WIDTH, default 16: signed width of operand a.
REQ-002 SHALL provide parameter DIN1_WIDTH, default 15: signed width of operand b.
REQ-003 SHALL provide parameter NUM_STAGE, default 3, legal range 1..6: number of multiplier pipeline registers.
REQ-004 SHALL provide parameter ACC_LEN, default 8, a power of two in the range 2..64: number of products summed per dot product.
REQ-005 SHALL provide parameter SHIFT, default 13, range 1..24: rounding right-shift applied at the output.
REQ-006 SHALL provide parameter DOUT_WIDTH, default 16: signed width of the saturated result.
REQ-007 SHALL provide port ap_clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-008 SHALL provide port ap_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL provide port mode, input, 1 bit: 0 = per-beat product, 1 = ACC_LEN-term dot product.
REQ-010 SHALL provide port in_valid, input, 1 bit, and port in_ready, output, 1 bit: operand handshake.
REQ-011 SHALL provide port din0, input, DIN0_WIDTH bits, and port din1, input, DIN1_WIDTH bits: signed operands.
REQ-012 SHALL provide port out_valid, output, 1 bit, and port out_ready, input, 1 bit: result handshake.
REQ-013 SHALL provide port dout, output, DOUT_WIDTH bits: signed rounded and saturated result.

Function
REQ-014 Beat accept SHALL be in_valid && in_ready; result transfer SHALL be out_valid && out_ready.
REQ-015 Global enable ce = !out_valid || out_ready; in_ready SHALL equal ce. When ce=0, every pipeline register, the counter and the accumulator SHALL hold.
REQ-016 Product SHALL be a full-precision signed product of DIN0_WIDTH+DIN1_WIDTH-1 bits, registered through NUM_STAGE stages, with a valid bit carried alongside each stage.
REQ-017 Accumulator width ACC_W SHALL be DIN0_WIDTH+DIN1_WIDTH-1+log2(ACC_LEN); the sum SHALL never overflow internally.
REQ-018 Output formation SHALL compute (sum + 2^(SHIFT-1)) arithmetically shifted right by SHIFT, then saturate to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
REQ-019 In mode 0, every accepted beat SHALL produce one result, with out_valid asserted NUM_STAGE+1 enabled cycles after the accept.
REQ-020 In mode 1, a beat counter (0..ACC_LEN-1) SHALL track the vector: at count 0 the accumulator loads the product, otherwise it adds the product. The ACC_LEN-th product SHALL produce one result, NUM_STAGE+1 enabled cycles after its accept. The counter SHALL wrap to 0.
REQ-021 Mode SHALL be captured with the first beat of a vector (count 0) and travel with the data. A mode change mid-vector SHALL take effect only after the vector completes.
REQ-022 Back-to-back vectors SHALL run with no bubble: a new vector's first product SHALL load the accumulator in the same cycle the previous sum is registered for output.
REQ-023 Throughput SHALL be one beat per cycle whenever out_ready=1.
REQ-024 When out_valid=1 and out_ready=0, dout SHALL stay stable until the transfer.

Reset
REQ-025 On ap_rst_n=0, out_valid, all stage valid bits, the counter, the accumulator, the captured mode and dout SHALL clear to 0 asynchronously. in_ready SHALL read 1 in the cycle after reset deasserts.
REQ-026 Reset mid-vector SHALL discard the partial sum. The next accepted beat SHALL be count 0.

Structure
REQ-027 A shared package dct_mac_pkg SHALL hold the mode encodings (MODE_MUL=0, MODE_DOT=1) and a function computing ACC_W.
REQ-028 The multiplier pipeline SHALL be one sub-module, dct_mac_mul_pipe, carrying a NUM_STAGE-deep data/valid shift register with an enable input. It SHALL be inferable to DSP48.

Verification
REQ-029 Mode 0, a=8192, b=100 -> dout=100 after 4 cycles (defaults).
REQ-030 Mode 0, a=-32768, b=16383 -> raw -65532, dout saturates to -32768. a=1, b=4096 -> 1 (round half up). a=-1, b=4096 -> 0.
REQ-031 Mode 1, eight beats a=4096, b=4096 -> exactly one result, 16384. Two consecutive vectors -> two results, with no input stall while out_ready=1.
REQ-032 Randomly drop out_ready for 1-5 cycles during mode-1 streaming -> in_ready low while out_valid && !out_ready. No lost, duplicated or altered results versus the reference model.
REQ-033 Assert ap_rst_n=0 after 5 beats of a vector, then send 8 beats of a=1, b=8192 -> single result 8 (the pre-reset partial sum is not included).
REQ-034 Toggle mode at beat 3 of a dot-product vector -> vector completes as mode 1. Mode 0 takes effect from the following beat.
